// File: rtl/idex_pipe_stage.sv
// D->E pipeline register with one-shot start/kill control for iterative units.
// Define IDEX_PERF_CNT_EN to add stall/flush performance counters.
module idex_pipe_stage #(
  parameter int          PAYLOAD_W = 160,
  parameter int          NUM_UNITS = 2,
  parameter logic [31:0] NOP_INST  = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_d_i,
  input  logic [31:0]          inst_d_i,
  input  logic [PAYLOAD_W-1:0] payload_d_i,
  input  logic [NUM_UNITS-1:0] unit_req_d_i,
  input  logic [NUM_UNITS-1:0] unit_done_i,
  output logic                 valid_e_o,
  output logic [31:0]          inst_e_o,
  output logic [PAYLOAD_W-1:0] payload_e_o,
  output logic [NUM_UNITS-1:0] start_e_o,
  output logic [NUM_UNITS-1:0] kill_e_o,
  output logic [NUM_UNITS-1:0] unit_busy_o,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]          perf_stall_cnt_o,
  output logic [31:0]          perf_flush_cnt_o,
`endif
  output logic                 stall_req_o
);

  logic                 valid_q;
  logic [31:0]          inst_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [NUM_UNITS-1:0] req_q;
  logic                 fresh_q;
  logic [NUM_UNITS-1:0] kill_q;
  logic [NUM_UNITS-1:0] busy_q;
  logic [NUM_UNITS-1:0] req_d;
  logic [NUM_UNITS-1:0] busy_live;

  assign req_d     = unit_req_d_i & {NUM_UNITS{valid_d_i}};
  assign busy_live = busy_q & ~unit_done_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      inst_q    <= NOP_INST;
      payload_q <= '0;
      req_q     <= '0;
      fresh_q   <= 1'b0;
      kill_q    <= '0;
      busy_q    <= '0;
    end else if (flush_i) begin
      valid_q   <= 1'b0;
      inst_q    <= NOP_INST;
      payload_q <= '0;
      req_q     <= '0;
      fresh_q   <= 1'b0;
      kill_q    <= busy_q;
      busy_q    <= '0;
    end else if (stall_i) begin
      fresh_q   <= 1'b0;
      kill_q    <= '0;
      busy_q    <= busy_live;
    end else begin
      valid_q   <= valid_d_i;
      inst_q    <= inst_d_i;
      payload_q <= payload_d_i;
      req_q     <= req_d;
      fresh_q   <= 1'b1;
      kill_q    <= '0;
      busy_q    <= busy_live | req_d;
    end
  end

  // req_q persists while held; fresh_q limits start to the first E cycle
  assign start_e_o   = req_q & {NUM_UNITS{fresh_q}};
  assign valid_e_o   = valid_q;
  assign inst_e_o    = inst_q;
  assign payload_e_o = payload_q;
  assign kill_e_o    = kill_q;
  assign unit_busy_o = busy_q;
  assign stall_req_o = |busy_live;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_req_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_i)     flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/idex_pipe_stage.md
# idex_pipe_stage

Parametrised decode-to-execute pipeline register for the RV32IM 5-stage core. It carries the decoded instruction and payload into E, with stall, flush and reset priority. It issues exactly one start pulse per multi-cycle instruction to each of NUM_UNITS iterative units (multiplier, divider, …). It tracks unit busy state and raises a stall request until the unit reports done.

## Interface
Parameters:
- PAYLOAD_W, 160: width of the bundled decode payload (rdata1/2, imm, PC, control fields, register addresses).
- NUM_UNITS, 2: number of multi-cycle execution units (bit 0 = mul, bit 1 = div).
- NOP_INST, 32'h00000013: instruction word inserted on flush/reset (addi x0,x0,0).

Ports:
- Reset is rst, asynchronous, active-high; clock is clk.
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- stall_i  in  1  hold E contents (from hazard unit).
- flush_i  in  1  insert bubble into E.
- valid_d_i  in  1  D-stage instruction valid.
- inst_d_i  in  32  D-stage instruction word.
- payload_d_i  in  PAYLOAD_W  D-stage decoded payload.
- unit_req_d_i  in  NUM_UNITS  instruction needs unit k (at most one bit set).
- unit_done_i  in  NUM_UNITS  one-cycle pulse: unit k result ready.
- valid_e_o  out  1  E-stage valid.
- inst_e_o  out  32  E-stage instruction.
- payload_e_o  out  PAYLOAD_W  E-stage payload.
- start_e_o  out  NUM_UNITS  one-cycle start pulse to unit k.
- kill_e_o  out  NUM_UNITS  one-cycle abort to unit k on flush of its in-flight op.
- unit_busy_o  out  NUM_UNITS  unit k has an in-flight op.
- stall_req_o  out  1  combinational: E must hold, a unit is still busy.

## Operation
- Priority per clock edge: rst > flush_i > stall_i > load.
- Load (!stall_i, !flush_i): E ← D fields; req_e_q ← unit_req_d_i & {NUM_UNITS{valid_d_i}}.
- Start: on a load where valid_d_i & unit_req_d_i[k], start_e_o[k]=1 for the following cycle only, and busy_q[k] is set. A held (stalled) instruction never re-pulses start.
- Done: unit_done_i[k] clears busy_q[k] on the next edge.
- Done and a new start for the same unit k on the same edge: busy_q[k] stays 1 and start_e_o[k] pulses.
- stall_req_o = |(busy_q & ~unit_done_i). It drops in the cycle done arrives, so the next instruction loads on that edge.
- Flush: valid_e_o=0, inst_e_o=NOP_INST, payload_e_o=0, req_e_q=0, start_e_o=0. For every k with busy_q[k]: kill_e_o[k]=1 for one cycle and busy_q[k] cleared. Flush overrides a simultaneous unit_done_i.
- Stall with no flush: all E registers hold; start_e_o forced 0; busy_q still updated by done.
- More than one bit set in unit_req_d_i is illegal. The behaviour is undefined; the bench flags it.

## Timing
- Reset values: valid_e_o=0, inst_e_o=NOP_INST, payload_e_o=0, start_e_o=0, kill_e_o=0, unit_busy_o=0, stall_req_o=0.
- Reset mid-operation clears busy without a kill pulse. Units are reset by the same rst.
- Latency D→E is 1 cycle.
- start_e_o is registered and coincides with the first cycle the instruction is valid in E.
- kill_e_o is registered and asserted the cycle after the flush edge.
- unit_busy_o is registered (busy_q).
- stall_req_o is the only combinational output: busy_q and unit_done_i to output, no other path.

## Configuration
- IDEX_PERF_CNT_EN defined: adds perf_stall_cnt_o[31:0] and perf_flush_cnt_o[31:0].
  - perf_stall_cnt_o counts cycles with stall_req_o=1.
  - perf_flush_cnt_o counts flush_i edges.
  - Both are reset to 0 and wrap at 2^32.
- IDEX_PERF_CNT_EN undefined: ports absent, no counter logic.

## Test plan
- Reset release, then load addi (valid=1, req=0) → next cycle valid_e_o=1, inst_e_o matches, start_e_o=0, stall_req_o=0.
- Load mul (req=2'b01), hold stall_i=1 for 5 cycles, done at cycle 6 → start_e_o[0] high exactly 1 cycle, unit_busy_o[0]=1 until the edge after done, stall_req_o low in the done cycle.
- Back-to-back mul: done[0] and load of new mul on the same edge → busy stays 1, second start pulse issued, no gap cycle.
- Flush while div busy (busy=2'b10) → inst_e_o=32'h00000013, valid_e_o=0, kill_e_o=2'b10 one cycle, busy=0, stall_req_o=0.
- Flush and stall simultaneously with a loaded instruction → flush wins, bubble inserted.
- rst asserted mid-mul (async, between edges) → all outputs immediately at reset values, no kill pulse; with IDEX_PERF_CNT_EN, counters read 0.
